// File: rtl/hazard_scoreboard.sv
// Issue-side hazard scoreboard for the XM23 pipeline: tracks pending GPR/PSW
// writes in a fixed-latency shift pipeline and withholds issue on RAW/WAW hazards.
module hazard_scoreboard #(
  parameter int LAT    = 2,
  parameter int BYPASS = 0,
  parameter int CW     = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          issue_valid,
  output logic          issue_ready,
  input  logic [2:0]    issue_src,
  input  logic [2:0]    issue_dst,
  input  logic          issue_src_rd,
  input  logic          issue_dst_rd,
  input  logic          issue_wb,
  input  logic          issue_psw_rd,
  input  logic          issue_psw_wr,
  input  logic          flush,
  output logic          wb_valid,
  output logic [2:0]    wb_dst,
  output logic          psw_wb,
  output logic [7:0]    busy,
  output logic          psw_busy,
  output logic [CW-1:0] issue_cnt,
  output logic [CW-1:0] stall_cnt
);

  typedef struct packed {
    logic       v;
    logic [2:0] dst;
    logic       wb;
    logic       pw;
  } stage_t;

  // With bypass, the retiring stage is invisible to the hazard check only.
  localparam int HAZ_LAST = (BYPASS != 0) ? LAT - 1 : LAT;

  stage_t     stg [1:LAT];
  logic [7:0] haz_busy;
  logic       haz_psw;
  logic       hazard;
  logic       accept;
  logic       stall;

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    busy     = '0;
    psw_busy = 1'b0;
    haz_busy = '0;
    haz_psw  = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      if (stg[k].v && stg[k].wb) busy[stg[k].dst] = 1'b1;
      if (stg[k].v && stg[k].pw) psw_busy = 1'b1;
      if (k <= HAZ_LAST) begin
        if (stg[k].v && stg[k].wb) haz_busy[stg[k].dst] = 1'b1;
        if (stg[k].v && stg[k].pw) haz_psw = 1'b1;
      end
    end
  end

  assign hazard = (issue_src_rd & haz_busy[issue_src])
                | (issue_dst_rd & haz_busy[issue_dst])
                | (issue_wb     & haz_busy[issue_dst])
                | (issue_psw_rd & haz_psw);

  // Gated by reset so nothing is offered while the scoreboard is held in reset.
  assign issue_ready = reset & en & ~flush & ~hazard;
  assign accept      = issue_valid & issue_ready;
  assign stall       = issue_valid & en & ~issue_ready;

  // Retire outputs come straight from the last stage, qualified by en so a
  // frozen pipeline never presents the same write-back twice.
  assign wb_valid = en & stg[LAT].v & stg[LAT].wb;
  assign wb_dst   = wb_valid ? stg[LAT].dst : 3'd0;
  assign psw_wb   = en & stg[LAT].v & stg[LAT].pw;

  // NOTE: sequential state uses non-blocking assignments only, so the stage
  // shift reads every old value before any stage is overwritten.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the stage array is small control state, not storage, so every
      // entry is cleared; in-flight ops must vanish on reset.
      for (int k = 1; k <= LAT; k++) stg[k] <= '0;
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else if (en) begin
      if (flush) begin
        for (int k = 1; k <= LAT; k++) stg[k] <= '0;
      end else begin
        for (int k = LAT; k >= 2; k--) stg[k] <= stg[k-1];
        stg[1] <= accept ? {1'b1, issue_dst, issue_wb, issue_psw_wr} : '0;
      end
      if (accept && issue_cnt != '1) issue_cnt <= issue_cnt + CW'(1);
      if (stall  && stall_cnt != '1) stall_cnt <= stall_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: dut0 is LAT=2/BYPASS=0/CW=16,
// dut1 is LAT=2/BYPASS=1/CW=2 (narrow counters to reach saturation quickly).
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b1;
  logic       flush = 1'b0;
  logic       issue_valid = 1'b0;
  logic [2:0] issue_src = '0;
  logic [2:0] issue_dst = '0;
  logic       issue_src_rd = 1'b0;
  logic       issue_dst_rd = 1'b0;
  logic       issue_wb = 1'b0;
  logic       issue_psw_rd = 1'b0;
  logic       issue_psw_wr = 1'b0;

  logic        r0, wv0, pw0, pb0;
  logic [2:0]  wd0;
  logic [7:0]  busy0;
  logic [15:0] ic0, sc0;

  logic        r1, wv1, pw1, pb1;
  logic [2:0]  wd1;
  logic [7:0]  busy1;
  logic [1:0]  ic1, sc1;

  int n_chk  = 0;
  int n_pass = 0;

  hazard_scoreboard #(.LAT(2), .BYPASS(0), .CW(16)) dut0 (
    .clk(clk), .reset(reset), .en(en), .issue_valid(issue_valid), .issue_ready(r0),
    .issue_src(issue_src), .issue_dst(issue_dst), .issue_src_rd(issue_src_rd),
    .issue_dst_rd(issue_dst_rd), .issue_wb(issue_wb), .issue_psw_rd(issue_psw_rd),
    .issue_psw_wr(issue_psw_wr), .flush(flush), .wb_valid(wv0), .wb_dst(wd0),
    .psw_wb(pw0), .busy(busy0), .psw_busy(pb0), .issue_cnt(ic0), .stall_cnt(sc0)
  );

  hazard_scoreboard #(.LAT(2), .BYPASS(1), .CW(2)) dut1 (
    .clk(clk), .reset(reset), .en(en), .issue_valid(issue_valid), .issue_ready(r1),
    .issue_src(issue_src), .issue_dst(issue_dst), .issue_src_rd(issue_src_rd),
    .issue_dst_rd(issue_dst_rd), .issue_wb(issue_wb), .issue_psw_rd(issue_psw_rd),
    .issue_psw_wr(issue_psw_wr), .flush(flush), .wb_valid(wv1), .wb_dst(wd1),
    .psw_wb(pw1), .busy(busy1), .psw_busy(pb1), .issue_cnt(ic1), .stall_cnt(sc1)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Cycle boundary: inputs change 1 time unit after the rising edge and
  // outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle();
    issue_valid  = 1'b0;
    issue_src    = '0;
    issue_dst    = '0;
    issue_src_rd = 1'b0;
    issue_dst_rd = 1'b0;
    issue_wb     = 1'b0;
    issue_psw_rd = 1'b0;
    issue_psw_wr = 1'b0;
  endtask

  task automatic op(input logic [2:0] s, input logic [2:0] d, input logic srd,
                    input logic drd, input logic w, input logic prd, input logic pwr);
    issue_valid  = 1'b1;
    issue_src    = s;
    issue_dst    = d;
    issue_src_rd = srd;
    issue_dst_rd = drd;
    issue_wb     = w;
    issue_psw_rd = prd;
    issue_psw_wr = pwr;
  endtask

  task automatic do_reset();
    idle();
    en    = 1'b1;
    flush = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    mid();
    n_chk++; if (r0 !== 1'b0) $display("FAIL reset_ready0: got %b want 0", r0); else n_pass++;
    n_chk++; if (r1 !== 1'b0) $display("FAIL reset_ready1: got %b want 0", r1); else n_pass++;
    n_chk++; if ({wv0, wd0, pw0, pb0} !== 6'd0) $display("FAIL reset_retire: got wv=%b wd=%0d pw=%b pb=%b want all 0", wv0, wd0, pw0, pb0); else n_pass++;
    n_chk++; if (busy0 !== 8'h00) $display("FAIL reset_busy: got %h want 00", busy0); else n_pass++;
    n_chk++; if (ic0 !== 16'd0 || sc0 !== 16'd0) $display("FAIL reset_counters: got %0d/%0d want 0/0", ic0, sc0); else n_pass++;
    tick();
    reset = 1'b1;
    op(3'd0, 3'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    mid();
    n_chk++; if (r0 !== 1'b1) $display("FAIL reset_first_ready: got %b want 1", r0); else n_pass++;
    tick();
    idle();
  endtask

  task automatic test_basic();
    do_reset();
    op(3'd1, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    mid();
    n_chk++; if (r0 !== 1'b1) $display("FAIL basic_c0_ready: got %b want 1", r0); else n_pass++;
    tick();
    op(3'd3, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    mid();
    n_chk++; if (r0 !== 1'b1) $display("FAIL basic_c1_ready: got %b want 1", r0); else n_pass++;
    n_chk++; if (busy0 !== 8'h01) $display("FAIL basic_c1_busy: got %h want 01", busy0); else n_pass++;
    tick();
    idle();
    mid();
    n_chk++; if (wv0 !== 1'b1 || wd0 !== 3'd0) $display("FAIL basic_c2_wb: got wv=%b wd=%0d want 1/0", wv0, wd0); else n_pass++;
    n_chk++; if (busy0 !== 8'h05) $display("FAIL basic_c2_busy: got %h want 05", busy0); else n_pass++;
    tick();
    mid();
    n_chk++; if (wv0 !== 1'b1 || wd0 !== 3'd2) $display("FAIL basic_c3_wb: got wv=%b wd=%0d want 1/2", wv0, wd0); else n_pass++;
    n_chk++; if (busy0 !== 8'h04) $display("FAIL basic_c3_busy: got %h want 04", busy0); else n_pass++;
    tick();
    mid();
    n_chk++; if (wv0 !== 1'b0 || wd0 !== 3'd0) $display("FAIL basic_c4_wb: got wv=%b wd=%0d want 0/0", wv0, wd0); else n_pass++;
    n_chk++; if (ic0 !== 16'd2 || sc0 !== 16'd0) $display("FAIL basic_counters: got %0d/%0d want 2/0", ic0, sc0); else n_pass++;
  endtask

  task automatic test_raw();
    do_reset();
    op(3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    op(3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    mid();
    n_chk++; if (r0 !== 1'b0) $display("FAIL raw_c1_ready: got %b want 0", r0); else n_pass++;
    tick();
    mid();
    n_chk++; if (r0 !== 1'b0) $display("FAIL raw_c2_ready: got %b want 0", r0); else n_pass++;
    n_chk++; if (wv0 !== 1'b1 || wd0 !== 3'd0) $display("FAIL raw_c2_wb: got wv=%b wd=%0d want 1/0", wv0, wd0); else n_pass++;
    tick();
    mid();
    n_chk++; if (r0 !== 1'b1) $display("FAIL raw_c3_ready: got %b want 1", r0); else n_pass++;
    tick();
    idle();
    mid();
    n_chk++; if (sc0 !== 16'd2 || ic0 !== 16'd2) $display("FAIL raw_counters: got stall=%0d issue=%0d want 2/2", sc0, ic0); else n_pass++;
    n_chk++; if (busy0 !== 8'h01) $display("FAIL raw_c4_busy: got %h want 01", busy0); else n_pass++;
    tick();
    mid();
    n_chk++; if (wv0 !== 1'b1 || wd0 !== 3'd0) $display("FAIL raw_c5_wb: got wv=%b wd=%0d want 1/0", wv0, wd0); else n_pass++;
    tick();
    mid();
    n_chk++; if (busy0 !== 8'h00) $display("FAIL raw_c6_busy: got %h want 00", busy0); else n_pass++;
  endtask

  task automatic test_bypass();
    do_reset();
    op(3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    op(3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    mid();
    n_chk++; if (r1 !== 1'b0) $display("FAIL bypass_c1_ready: got %b want 0", r1); else n_pass++;
    tick();
    mid();
    n_chk++; if (r1 !== 1'b1) $display("FAIL bypass_c2_ready: got %b want 1", r1); else n_pass++;
    n_chk++; if (wv1 !== 1'b1 || busy1 !== 8'h01) $display("FAIL bypass_c2_retire: got wv=%b busy=%h want 1/01", wv1, busy1); else n_pass++;
    tick();
    idle();
    mid();
    n_chk++; if (sc1 !== 2'd1 || ic1 !== 2'd2) $display("FAIL bypass_counters: got stall=%0d issue=%0d want 1/2", sc1, ic1); else n_pass++;
    n_chk++; if (busy1 !== 8'h01) $display("FAIL bypass_c3_busy: got %h want 01", busy1); else n_pass++;
    tick();
    tick();
    mid();
    n_chk++; if (busy1 !== 8'h00) $display("FAIL bypass_drain_busy: got %h want 00", busy1); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      op(3'd0, 3'(i + 1), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      mid();
      n_chk++; if (r0 !== 1'b1 || r1 !== 1'b1) $display("FAIL b2b_ready_%0d: got %b%b want 11", i, r0, r1); else n_pass++;
      tick();
    end
    idle();
    mid();
    n_chk++; if (ic0 !== 16'd5) $display("FAIL b2b_issue_cnt: got %0d want 5", ic0); else n_pass++;
    n_chk++; if (ic1 !== 2'd3) $display("FAIL b2b_issue_cnt_sat: got %0d want 3", ic1); else n_pass++;
    n_chk++; if (busy0 !== 8'h30) $display("FAIL b2b_busy: got %h want 30", busy0); else n_pass++;
  endtask

  task automatic test_psw();
    int pulses;
    pulses = 0;
    do_reset();
    op(3'd0, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    mid();
    pulses += int'(pw0);
    tick();
    op(3'd0, 3'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    mid();
    pulses += int'(pw0);
    n_chk++; if (pb0 !== 1'b1 || r0 !== 1'b0) $display("FAIL psw_c1: got psw_busy=%b ready=%b want 1/0", pb0, r0); else n_pass++;
    tick();
    mid();
    pulses += int'(pw0);
    n_chk++; if (r0 !== 1'b0) $display("FAIL psw_c2_ready: got %b want 0", r0); else n_pass++;
    tick();
    mid();
    pulses += int'(pw0);
    n_chk++; if (r0 !== 1'b1) $display("FAIL psw_c3_ready: got %b want 1", r0); else n_pass++;
    tick();
    idle();
    mid();
    pulses += int'(pw0);
    tick();
    mid();
    pulses += int'(pw0);
    n_chk++; if (wv0 !== 1'b1 || wd0 !== 3'd5) $display("FAIL psw_addc_wb: got wv=%b wd=%0d want 1/5", wv0, wd0); else n_pass++;
    tick();
    mid();
    pulses += int'(pw0);
    n_chk++; if (pulses != 1) $display("FAIL psw_wb_pulses: got %0d want 1", pulses); else n_pass++;
    n_chk++; if (pb0 !== 1'b0) $display("FAIL psw_busy_end: got %b want 0", pb0); else n_pass++;
  endtask

  task automatic test_flush();
    do_reset();
    op(3'd0, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    op(3'd0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    mid();
    n_chk++; if (r0 !== 1'b1) $display("FAIL flush_c1_ready: got %b want 1", r0); else n_pass++;
    tick();
    op(3'd0, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    flush = 1'b1;
    mid();
    n_chk++; if (wv0 !== 1'b1 || wd0 !== 3'd1) $display("FAIL flush_retire: got wv=%b wd=%0d want 1/1", wv0, wd0); else n_pass++;
    n_chk++; if (r0 !== 1'b0) $display("FAIL flush_ready: got %b want 0", r0); else n_pass++;
    tick();
    flush = 1'b0;
    idle();
    mid();
    n_chk++; if (wv0 !== 1'b0 || busy0 !== 8'h00) $display("FAIL flush_after: got wv=%b busy=%h want 0/00", wv0, busy0); else n_pass++;
    n_chk++; if (ic0 !== 16'd2) $display("FAIL flush_issue_cnt: got %0d want 2", ic0); else n_pass++;
    tick();
    mid();
    n_chk++; if (wv0 !== 1'b0) $display("FAIL flush_no_r2: got wv=%b want 0", wv0); else n_pass++;
  endtask

  task automatic test_en_reset();
    do_reset();
    op(3'd0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    en = 1'b0;
    op(3'd0, 3'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    mid();
    n_chk++; if (wv0 !== 1'b0 || r0 !== 1'b0) $display("FAIL en0_c2: got wv=%b ready=%b want 0/0", wv0, r0); else n_pass++;
    n_chk++; if (busy0 !== 8'h08) $display("FAIL en0_busy: got %h want 08", busy0); else n_pass++;
    tick();
    tick();
    mid();
    n_chk++; if (wv0 !== 1'b0 || busy0 !== 8'h08) $display("FAIL en0_c4: got wv=%b busy=%h want 0/08", wv0, busy0); else n_pass++;
    n_chk++; if (ic0 !== 16'd1 || sc0 !== 16'd0) $display("FAIL en0_counters: got %0d/%0d want 1/0", ic0, sc0); else n_pass++;
    tick();
    en = 1'b1;
    mid();
    n_chk++; if (wv0 !== 1'b1 || wd0 !== 3'd3 || r0 !== 1'b1) $display("FAIL en1_retire: got wv=%b wd=%0d ready=%b want 1/3/1", wv0, wd0, r0); else n_pass++;
    #1 reset = 1'b0;
    #1;
    n_chk++; if (wv0 !== 1'b0 || busy0 !== 8'h00 || ic0 !== 16'd0 || r0 !== 1'b0) $display("FAIL midreset_outputs: got wv=%b busy=%h ic=%0d ready=%b want 0/00/0/0", wv0, busy0, ic0, r0); else n_pass++;
    tick();
    mid();
    n_chk++; if (wv0 !== 1'b0 || busy0 !== 8'h00) $display("FAIL midreset_held: got wv=%b busy=%h want 0/00", wv0, busy0); else n_pass++;
    tick();
    reset = 1'b1;
    idle();
    mid();
    n_chk++; if (wv0 !== 1'b0 || busy0 !== 8'h00) $display("FAIL postreset_c0: got wv=%b busy=%h want 0/00", wv0, busy0); else n_pass++;
    tick();
    mid();
    n_chk++; if (wv0 !== 1'b0 || pw0 !== 1'b0) $display("FAIL postreset_c1: got wv=%b pw=%b want 0/0", wv0, pw0); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_raw();
    test_bypass();
    test_back_to_back();
    test_psw();
    test_flush();
    test_en_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Issue-side scheduler between decode_stage and the execute/ALU path of the XM23 pipeline.
- Accepts one decoded instruction per cycle over a valid/ready handshake and tracks in-flight writes to the 8 GPRs and the PSW in a fixed-latency shift pipeline.
- Withholds ready on RAW/WAW hazards and emits a write-back strobe when each op retires.
- Replaces the async_set/async_dep stall derivation of pipeline_controller with per-register tracking.

Parameters:
- LAT, 2, cycles from issue acceptance to write-back; legal range 1..4.
- BYPASS, 0, 1 = a register retiring this cycle counts as free for a same-cycle issue; 0 = it still counts as busy.
- CW, 16, width of the saturating performance counters.

Ports:
- clk  in  1  pipeline clock (divided clock from top level).
- reset  in  1  asynchronous, active-low; 0 = reset asserted.
- en  in  1  clock enable; 0 freezes all state, and issue_ready is forced 0.
- issue_valid  in  1  decode presents an instruction.
- issue_ready  out  1  scoreboard accepts the instruction this cycle.
- issue_src  in  3  source register number.
- issue_dst  in  3  destination register number.
- issue_src_rd  in  1  instruction reads issue_src (0 for constant / RC=1 forms).
- issue_dst_rd  in  1  instruction reads issue_dst as an operand (ADD, SUB, BIS, ...).
- issue_wb  in  1  instruction writes issue_dst.
- issue_psw_rd  in  1  instruction reads PSW.C (ADDC/SUBC).
- issue_psw_wr  in  1  instruction updates PSW flags.
- flush  in  1  discard all in-flight ops (branch / exception).
- wb_valid  out  1  one-cycle strobe when an op with issue_wb=1 retires.
- wb_dst  out  3  register written by the retiring op; 0 when wb_valid=0.
- psw_wb  out  1  retiring op updates PSW.
- busy  out  8  per-register pending-write mask.
- psw_busy  out  1  PSW write pending.
- issue_cnt  out  CW  accepted instructions, saturating.
- stall_cnt  out  CW  cycles with issue_valid=1, en=1 and issue_ready=0, saturating.

Behaviour:
- Reset (reset=0, async): all stage valid bits 0; busy=0, psw_busy=0, wb_valid=0, wb_dst=0, psw_wb=0, issue_cnt=0, stall_cnt=0, issue_ready=0. The first acceptance is possible in the first en=1 cycle after reset deassertion.
- Tracking: stages S1..S_LAT, each holding {v, dst, wb, pw}.
  - Acceptance (issue_valid & issue_ready) loads S1.
  - Each en cycle shifts S(k) into S(k+1).
  - S_LAT drives the retire outputs combinationally: wb_valid = v&wb, wb_dst = dst when wb_valid, psw_wb = v&pw.
- busy[r] = OR over stages of (v & wb & dst==r); psw_busy = OR of (v & pw).
  - With BYPASS=1, the S_LAT stage is excluded from the hazard check only, not from the busy output.
- Hazards; issue_ready=1 iff en=1, flush=0 and none of the following hold:
  - issue_src_rd and busy[issue_src] (RAW).
  - issue_dst_rd and busy[issue_dst] (RAW).
  - issue_wb and busy[issue_dst] (WAW).
  - issue_psw_rd and psw_busy.
  - issue_ready is combinational from the inputs and current state and must not depend on issue_valid.
- Handshake: decode holds all issue_* fields stable while issue_valid=1 and issue_ready=0. An accepted op occupies exactly one slot. Throughput is 1 op/cycle when hazard-free.
- Latency: an op accepted in cycle t retires with wb_valid high in cycle t+LAT. Its busy bit is set from t+1 through t+LAT inclusive.
- Simultaneous retire and issue to the same register:
  - BYPASS=0: stall for one cycle.
  - BYPASS=1: accept; the new op sets busy again from the next cycle.
- flush=1 (sampled on an en cycle):
  - All stage valid bits clear at the next edge.
  - The retire outputs in the flush cycle itself still reflect S_LAT; the flush does not suppress a write-back that is already at retirement.
  - issue_ready=0 during flush.
- en=0: no shift, no acceptance, no counter change. Retire outputs hold their S_LAT values but are qualified 0 (wb_valid=0, psw_wb=0) so downstream does not double-write.
- Counters increment by 1 per qualifying cycle and stop at 2^CW-1. Only reset clears them.
- Reset asserted mid-operation drops all in-flight ops immediately; no write-back strobe is produced.

Test Plan:
- LAT=2, BYPASS=0: issue ADD dst=R0, src=R1 (wb=1, dst_rd=1) at cycle 0, then R2←R3 at cycle 1 -> both accepted. wb_valid at cycles 2 and 3 with wb_dst=0 then 2. busy=0x01 at cycle 1 and 0x05 at cycle 2.
- RAW: R0 written at cycle 0, then an op reading src=R0 presented at cycle 1 -> issue_ready=0 in cycles 1–2, accepted in cycle 3; stall_cnt=2.
- BYPASS=1, same sequence -> stalls only in cycle 1, accepted in cycle 2; stall_cnt=1.
- PSW: ADD with psw_wr=1, then ADDC (psw_rd=1, dst=R5) -> ADDC waits until psw_busy=0. psw_wb pulses exactly once.
- Flush: two ops in flight (R1, R2) and flush at the cycle R1 retires -> wb_valid for R1 only. R2 never retires, and busy=0 the next cycle.
- en toggled 0 for 3 cycles mid-flight, then reset pulled low mid-flight -> no shift or counter change while en=0. After reset, all outputs are 0 and no wb_valid strobe is produced.
